uart_command_parser: RTL and testbench
======================================

// Module: uart_command_parser
// PURPOSE
//  Receive-side partner of the histogram message formatter: parses line-based ASCII commands arriving from the
//  simpleuart RX byte stream into (command, argument) pairs for the test controller (delay select, sweep start).
//  Sits between simpleuart RX output and the IDELAY/histogram control logic in the CLK domain.
// PARAMETERS
//  ARG_DIGITS   4          max hex digits per argument; ARG_BITS = 4*ARG_DIGITS (localparam)
//  TIMEOUT      1000000    CLK cycles of inter-byte silence that abort a partial line; 0 = timeout disabled
// PORTS
//  CLK          in   1         single clock, all logic on rising edge
//  RSTN         in   1         asynchronous, active-low reset
//  I_STB        in   1         1-cycle strobe: I_DAT holds a received byte
//  I_DAT        in   8         received ASCII byte
//  O_STB        out  1         command valid; held until O_ACK
//  O_CMD        out  8         command letter, upper-case folded
//  O_ARG        out  ARG_BITS  argument, right-aligned, zero if no digits given
//  O_ACK        in   1         consumer accepts command (sampled only while O_STB=1)
//  O_ERR        out  1         1-cycle error pulse
//  O_ERR_CODE   out  2         0 bad char, 1 too many digits, 2 byte dropped while busy, 3 timeout; valid with O_ERR
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, arg/count/timer cleared. Reset mid-line discards the partial command.
//  EOL = CR (0x0D) or LF (0x0A). SPACE (0x20) ignored in IDLE and ARG.
//  IDLE: EOL ignored; letter A-Z/a-z -> O_CMD<=upper(letter), arg<=0, cnt<=0, -> ARG; other byte -> ERR(0), -> SKIP.
//  ARG:  hex digit (0-9,A-F,a-f): if cnt<ARG_DIGITS arg<={arg[ARG_BITS-5:0],nib}, cnt++; else ERR(1), -> SKIP.
//        EOL -> DONE, O_ARG<=arg, O_STB<=1 on next edge (1 cycle latency from EOL strobe). Other -> ERR(0), -> SKIP.
//  SKIP: discard bytes until EOL -> IDLE. No further ERR pulses while in SKIP.
//  DONE: O_STB=1, O_CMD/O_ARG stable. O_ACK -> O_STB<=0, -> IDLE.
//        I_STB without O_ACK in same cycle: byte dropped, ERR(2), stay DONE.
//        I_STB with O_ACK in same cycle: command retired and byte processed exactly as in IDLE (no drop).
//  Timeout: timer clears on every I_STB; counts only in ARG/SKIP; reaching TIMEOUT -> IDLE; from ARG also ERR(3).
//        Never active in IDLE/DONE. TIMEOUT=0 removes counter logic.
//  O_ERR is high exactly one cycle per event; at most one event per byte.
//  Timer width $clog2(TIMEOUT+1); saturates, never wraps. cnt width $clog2(ARG_DIGITS+1).
// CONFIGURATION
//  UART_COMMAND_PARSER_ECHO_EN defined: extra ports O_ECHO_STB out 1, O_ECHO_DAT out 8, I_ECHO_BSY in 1.
//    Every I_STB byte is echoed 1 cycle later (O_ECHO_STB pulse) unless I_ECHO_BSY=1, in which case the echo
//    alone is dropped; parsing is unaffected. Dropped-while-DONE bytes are still echoed.
//  Not defined: echo ports and logic absent; parser behaviour identical.
// STRUCTURE
//  uart_command_parser_pkg: state encoding (IDLE/ARG/SKIP/DONE), ERR_* code constants, ASCII constants
//    (CR, LF, SPACE).
//  Sub-module hex_nibble_decoder: combinational byte -> {valid, nib[3:0]}; one instance.
//  Parser FSM, arg shift register, digit counter, timeout counter in top module.
// TESTING
//  "D1F\r" (ARG_DIGITS=4) -> O_STB 1 cycle after CR, O_CMD=0x44, O_ARG=0x001F; held until O_ACK, then 0.
//  "s\n" -> O_CMD=0x53, O_ARG=0; "x ab\n" -> O_CMD=0x58, O_ARG=0x00AB.
//  "D12345\n" -> ERR code 1 on the '5'; no O_STB; following "D7\n" -> O_ARG=0x0007.
//  "#D1\n" -> ERR code 0 on '#', line skipped, no O_STB.
//  O_STB pending + byte 'A' without ACK -> ERR code 2, O_STB stays; 'A' with ACK same cycle -> no ERR,
//    next "5\n" -> O_CMD=0x41, O_ARG=0x0005.
//  TIMEOUT=100: "D3" then 100 idle cycles -> ERR code 3, IDLE; later "\n" produces nothing. RSTN low
//    mid-line -> all outputs 0.

Source files
------------

// File: rtl/uart_command_parser_pkg.sv
// Shared state encoding, error codes and ASCII constants for the UART command parser.
package uart_command_parser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG  = 2'd1,
      ST_SKIP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] ERR_BAD_CHAR  = 2'd0;
   localparam logic [1:0] ERR_TOO_MANY  = 2'd1;
   localparam logic [1:0] ERR_BUSY_DROP = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   function automatic logic is_eol(input logic [7:0] b);
      return (b == ASCII_CR) || (b == ASCII_LF);
   endfunction

   function automatic logic is_letter(input logic [7:0] b);
      return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
   endfunction

   // Clearing bit 5 folds a-z onto A-Z; only applied to bytes already known to be letters.
   function automatic logic [7:0] to_upper(input logic [7:0] b);
      return b & 8'hDF;
   endfunction

endpackage

// File: rtl/uart_command_parser_hex_nibble_decoder.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f -> {valid, nibble}.
module uart_command_parser_hex_nibble_decoder (
   input  logic [7:0] dat,
   output logic       valid,
   output logic [3:0] nib
);

   always_comb begin
      valid = 1'b0;
      nib   = 4'h0;
      if ((dat >= 8'h30) && (dat <= 8'h39)) begin
         valid = 1'b1;
         nib   = dat[3:0];
      end else if (((dat >= 8'h41) && (dat <= 8'h46)) || ((dat >= 8'h61) && (dat <= 8'h66))) begin
         valid = 1'b1;
         nib   = dat[3:0] + 4'd9;
      end
   end

endmodule

// File: rtl/uart_command_parser.sv
// Line-based ASCII command parser: "<letter>[hex digits]<CR|LF>" -> (cmd, arg) with ack handshake.
// Optional byte echo path enabled by defining UART_COMMAND_PARSER_ECHO_EN.
//
// state | meaning
// IDLE  | waiting for a command letter; EOL and spaces ignored
// ARG   | collecting hex digits of the argument
// SKIP  | discarding the rest of a bad line until EOL
// DONE  | command presented on o_stb, waiting for o_ack
module uart_command_parser
   import uart_command_parser_pkg::*;
#(
   parameter int ARG_DIGITS = 4,
   parameter int TIMEOUT    = 1000000,
   localparam int ARG_BITS  = 4 * ARG_DIGITS
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef UART_COMMAND_PARSER_ECHO_EN
   output logic                o_echo_stb,
   output logic [7:0]          o_echo_dat,
   input  logic                i_echo_bsy,
`endif
   input  logic                i_stb,
   input  logic [7:0]          i_dat,
   output logic                o_stb,
   output logic [7:0]          o_cmd,
   output logic [ARG_BITS-1:0] o_arg,
   input  logic                o_ack,
   output logic                o_err,
   output logic [1:0]          o_err_code
);

   localparam int CNT_W = $clog2(ARG_DIGITS + 1);

   state_t              state_q, state_d, cur_state;
   logic [ARG_BITS-1:0] arg_q, arg_d;
   logic [ARG_BITS-1:0] out_arg_q, out_arg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [7:0]          cmd_q, cmd_d;
   logic                err_d;
   logic [1:0]          err_code_d;
   logic                hex_valid;
   logic [3:0]          hex_nib;
   logic                timeout_hit;

   uart_command_parser_hex_nibble_decoder u_hex (
      .dat   (i_dat),
      .valid (hex_valid),
      .nib   (hex_nib)
   );

   generate
      if (TIMEOUT > 0) begin : g_timer
         localparam int TW = $clog2(TIMEOUT + 1);
         logic [TW-1:0] timer_q;
         logic          counting;

         assign counting = (state_q == ST_ARG) || (state_q == ST_SKIP);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               timer_q <= '0;
            else if (i_stb || !counting)
               timer_q <= '0;
            else if (timer_q != TW'(TIMEOUT))
               timer_q <= timer_q + TW'(1);
         end

         // Fires on the TIMEOUT-th silent cycle; a byte arriving that cycle wins.
         assign timeout_hit = counting && !i_stb && (timer_q == TW'(TIMEOUT - 1));
      end else begin : g_no_timer
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      arg_d      = arg_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      out_arg_d  = out_arg_q;
      err_d      = 1'b0;
      err_code_d = ERR_BAD_CHAR;

      // An ack retires the pending command; a byte in the same cycle is handled as in IDLE.
      cur_state = state_q;
      if ((state_q == ST_DONE) && o_ack) begin
         cur_state = ST_IDLE;
         state_d   = ST_IDLE;
      end

      if (timeout_hit) begin
         state_d = ST_IDLE;
         if (state_q == ST_ARG) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
         end
      end else if (i_stb) begin
         case (cur_state)
            ST_IDLE: begin
               if (is_eol(i_dat) || (i_dat == ASCII_SPACE)) begin
                  state_d = ST_IDLE;
               end else if (is_letter(i_dat)) begin
                  cmd_d   = to_upper(i_dat);
                  arg_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_ARG;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BAD_CHAR;
                  state_d    = ST_SKIP;
               end
            end
            ST_ARG: begin
               if (i_dat == ASCII_SPACE) begin
                  state_d = ST_ARG;
               end else if (hex_valid) begin
                  if (cnt_q < CNT_W'(ARG_DIGITS)) begin
                     arg_d = (arg_q << 4) | ARG_BITS'(hex_nib);
                     cnt_d = cnt_q + CNT_W'(1);
                  end else begin
                     err_d      = 1'b1;
                     err_code_d = ERR_TOO_MANY;
                     state_d    = ST_SKIP;
                  end
               end else if (is_eol(i_dat)) begin
                  out_arg_d = arg_q;
                  state_d   = ST_DONE;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_BAD_CHAR;
                  state_d    = ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (is_eol(i_dat))
                  state_d = ST_IDLE;
            end
            ST_DONE: begin
               err_d      = 1'b1;
               err_code_d = ERR_BUSY_DROP;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         arg_q      <= '0;
         cnt_q      <= '0;
         cmd_q      <= '0;
         out_arg_q  <= '0;
         o_err      <= 1'b0;
         o_err_code <= 2'd0;
      end else begin
         state_q    <= state_d;
         arg_q      <= arg_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         out_arg_q  <= out_arg_d;
         o_err      <= err_d;
         o_err_code <= err_code_d;
      end
   end

   assign o_stb = (state_q == ST_DONE);
   assign o_cmd = cmd_q;
   assign o_arg = out_arg_q;

`ifdef UART_COMMAND_PARSER_ECHO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_echo_stb <= 1'b0;
         o_echo_dat <= 8'h00;
      end else begin
         o_echo_stb <= i_stb && !i_echo_bsy;
         if (i_stb)
            o_echo_dat <= i_dat;
      end
   end
`endif

endmodule

// File: tb/tb_uart_command_parser.sv
// Self-checking bench for uart_command_parser: directed scenarios plus random lines vs a string-level model.
module tb_uart_command_parser;

   localparam int ARG_DIGITS = 4;
   localparam int TIMEOUT    = 100;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_stb = 1'b0;
   logic [7:0]  i_dat = 8'h00;
   logic        o_ack = 1'b0;
   logic        o_stb;
   logic [7:0]  o_cmd;
   logic [15:0] o_arg;
   logic        o_err;
   logic [1:0]  o_err_code;
`ifdef UART_COMMAND_PARSER_ECHO_EN
   logic        o_echo_stb;
   logic [7:0]  o_echo_dat;
   logic        i_echo_bsy = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [1:0] err_q[$];

   typedef struct {
      bit        has_cmd;
      bit [7:0]  cmd;
      bit [15:0] arg;
      int        n_err;
      bit [1:0]  code;
   } pred_t;

   always #5 clk = ~clk;

   uart_command_parser #(.ARG_DIGITS(ARG_DIGITS), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef UART_COMMAND_PARSER_ECHO_EN
      .o_echo_stb (o_echo_stb),
      .o_echo_dat (o_echo_dat),
      .i_echo_bsy (i_echo_bsy),
`endif
      .i_stb      (i_stb),
      .i_dat      (i_dat),
      .o_stb      (o_stb),
      .o_cmd      (o_cmd),
      .o_arg      (o_arg),
      .o_ack      (o_ack),
      .o_err      (o_err),
      .o_err_code (o_err_code)
   );

   always @(negedge clk)
      if (rst_n && o_err) err_q.push_back(o_err_code);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Model: interpret one line body (no EOL) straight from the command grammar.
   function automatic int hexval(input byte unsigned c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      return -1;
   endfunction

   function automatic pred_t predict(input byte unsigned body[$]);
      pred_t p;
      int i = 0;
      int nd = 0;
      int v;
      p = '{has_cmd: 0, cmd: 0, arg: 0, n_err: 0, code: 0};
      while (i < body.size() && body[i] == " ") i++;
      if (i == body.size()) return p;
      if (body[i] >= "a" && body[i] <= "z") p.cmd = body[i] - 8'd32;
      else if (body[i] >= "A" && body[i] <= "Z") p.cmd = body[i];
      else begin p.n_err = 1; p.code = 0; return p; end
      i++;
      for (; i < body.size(); i++) begin
         if (body[i] == " ") continue;
         v = hexval(body[i]);
         if (v < 0) begin p.n_err = 1; p.code = 0; return p; end
         if (nd == ARG_DIGITS) begin p.n_err = 1; p.code = 1; return p; end
         p.arg = p.arg * 16 + 16'(v);
         nd++;
      end
      p.has_cmd = 1;
      return p;
   endfunction

   // Called at a falling edge; returns at the falling edge after the byte was sampled.
   task automatic send_byte(input logic [7:0] b);
      i_stb = 1'b1;
      i_dat = b;
      @(negedge clk);
      i_stb = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int k = 0; k < s.len(); k++) send_byte(s[k]);
   endtask

   task automatic do_ack();
      o_ack = 1'b1;
      @(negedge clk);
      o_ack = 1'b0;
   endtask

   task automatic expect_errs(input string tag, input int n, input logic [1:0] code);
      @(negedge clk);
      #1;
      check({tag, "_nerr"}, err_q.size(), n);
      if (n > 0 && err_q.size() > 0) check({tag, "_code"}, err_q[0], code);
      err_q.delete();
   endtask

   task automatic run_line(input string tag, input string body, input logic [7:0] eol,
                           input bit exp_has, input logic [7:0] exp_cmd, input logic [15:0] exp_arg,
                           input int n_err, input logic [1:0] code);
      send_str(body);
      send_byte(eol);
      check({tag, "_stb"}, o_stb, exp_has);
      if (exp_has) begin
         check({tag, "_cmd"}, o_cmd, exp_cmd);
         check({tag, "_arg"}, o_arg, exp_arg);
      end
      if (o_stb) do_ack();
      expect_errs(tag, n_err, code);
   endtask

   initial begin
      string pool;
      byte unsigned q[$];
      pred_t p;
      int len;

      pool = "ABDFGXYZabcdfgxz0123456789  #-.";

      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_stb", o_stb, 0);
      check("rst_cmd", o_cmd, 0);
      check("rst_arg", o_arg, 0);
      check("rst_err", o_err, 0);
      check("rst_code", o_err_code, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send_str("D1F");
      send_byte(CR);
      check("d1f_stb", o_stb, 1);
      check("d1f_cmd", o_cmd, 8'h44);
      check("d1f_arg", o_arg, 16'h001F);
      repeat (3) @(negedge clk);
      check("d1f_hold", o_stb, 1);
      do_ack();
      check("d1f_acked", o_stb, 0);
      expect_errs("d1f", 0, 0);

      run_line("s", "s", LF, 1, 8'h53, 16'h0000, 0, 0);
      run_line("xab", "x ab", LF, 1, 8'h58, 16'h00AB, 0, 0);
      run_line("toolong", "D12345", LF, 0, 0, 0, 1, 2'd1);
      run_line("d7", "D7", LF, 1, 8'h44, 16'h0007, 0, 0);
      run_line("hash", "#D1", LF, 0, 0, 0, 1, 2'd0);

      // Byte arriving while a command is pending.
      send_str("D1");
      send_byte(LF);
      check("pend_stb", o_stb, 1);
      send_byte("A");
      check("drop_stb", o_stb, 1);
      check("drop_cmd", o_cmd, 8'h44);
      check("drop_arg", o_arg, 16'h0001);
      expect_errs("drop", 1, 2'd2);
      o_ack = 1'b1;
      send_byte("A");
      o_ack = 1'b0;
      check("ackbyte_stb", o_stb, 0);
      expect_errs("ackbyte", 0, 0);
      run_line("ack5", "5", LF, 1, 8'h41, 16'h0005, 0, 0);

      // Silence just short of the limit keeps the line alive.
      send_str("D3");
      repeat (TIMEOUT - 1) @(negedge clk);
      run_line("nearto", "", LF, 1, 8'h44, 16'h0003, 0, 0);

      send_str("D3");
      repeat (TIMEOUT) @(negedge clk);
      expect_errs("timeout", 1, 2'd3);
      run_line("after_to", "", LF, 0, 0, 0, 0, 0);

      send_byte("#");
      repeat (TIMEOUT) @(negedge clk);
      expect_errs("skip_to", 1, 2'd0);
      run_line("after_skip", "D2", CR, 1, 8'h44, 16'h0002, 0, 0);

      for (int n = 0; n < 60; n++) begin
         q.delete();
         len = $urandom_range(0, 7);
         for (int k = 0; k < len; k++) begin
            if (k == 0 && $urandom_range(0, 9) < 7)
               q.push_back(pool[$urandom_range(0, 15)]);
            else
               q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
         end
         p = predict(q);
         foreach (q[k]) begin
            send_byte(q[k]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         send_byte(($urandom_range(0, 1) == 1) ? CR : LF);
         check("rnd_stb", o_stb, p.has_cmd);
         if (p.has_cmd) begin
            check("rnd_cmd", o_cmd, p.cmd);
            check("rnd_arg", o_arg, p.arg);
         end
         if (o_stb) do_ack();
         expect_errs("rnd", p.n_err, p.code);
      end

      // Reset in the middle of a line.
      send_str("D5");
      rst_n = 1'b0;
      #2;
      check("midrst_stb", o_stb, 0);
      check("midrst_cmd", o_cmd, 0);
      check("midrst_arg", o_arg, 0);
      check("midrst_err", o_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      err_q.delete();
      @(negedge clk);
      run_line("after_rst", "", LF, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
